// File: rtl/round_controller.sv
// Round sequencer for the Not Not game.
// Each round steps the prompt LFSRs once, waits one settle cycle, and then
// counts down while it waits for an answer. The round is judged against the
// colour/not logic result, and score and lives are updated until game over.
//
// Pulse semantics: start and submit are single-cycle strobes. Each is acted on
// only in the cycle it is high, and only in a state that accepts it (start in
// IDLE/OVER, submit in WAIT). In any other state the strobe is dropped and not
// remembered. draw_en, hit and miss are single-cycle registered strobes.
module round_controller #(
  parameter int TICKS_PER_ROUND = 50000000,
  parameter int TW              = $clog2(TICKS_PER_ROUND),
  parameter int SCORE_W         = 8,
  parameter int LIVES           = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               submit,
  input  logic [3:0]         answer,
  input  logic [3:0]         expected,
  output logic               draw_en,
  output logic               playing,
  output logic               game_over,
  output logic [TW-1:0]      time_left,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               hit,
  output logic               miss,
  output logic [2:0]         dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRAW   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_JUDGE  = 3'd4;
  localparam logic [2:0] S_OVER   = 3'd5;

  localparam logic [TW-1:0]      TIME_LOAD = TW'(TICKS_PER_ROUND - 1);
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  logic [2:0]         state_q, state_d;
  logic [TW-1:0]      time_q, time_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic               draw_q, draw_d;
  // hit_q/miss_q hold the verdict taken on the deciding WAIT cycle; the
  // JUDGE cycle applies it to score/lives, so no extra answer latch is needed.
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;

  // Next-state, countdown and scoring decisions.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    score_d = score_q;
    lives_d = lives_q;
    draw_d  = 1'b0;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_DRAW;
          draw_d  = 1'b1;
          score_d = '0;
          lives_d = LIVES_INIT;
        end
      end
      S_DRAW: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        time_d  = TIME_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A submit on the last tick beats the timeout.
        if (submit) begin
          state_d = S_JUDGE;
          time_d  = '0;
          hit_d   = (answer == expected);
          miss_d  = (answer != expected);
        end else if (time_q == '0) begin
          state_d = S_JUDGE;
          miss_d  = 1'b1;
        end else begin
          time_d = time_q - 1'b1;
        end
      end
      S_JUDGE: begin
        time_d = '0;
        if (hit_q) begin
          if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
          state_d = S_DRAW;
          draw_d  = 1'b1;
        end else begin
          lives_d = lives_q - 3'd1;
          if (lives_q == 3'd1) begin
            state_d = S_OVER;
          end else begin
            state_d = S_DRAW;
            draw_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any round without a verdict.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      time_q  <= '0;
      score_q <= '0;
      lives_q <= LIVES_INIT;
      draw_q  <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      score_q <= score_d;
      lives_q <= lives_d;
      draw_q  <= draw_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign draw_en   = draw_q;
  assign time_left = time_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign playing   = (state_q == S_DRAW) || (state_q == S_SETTLE) ||
                     (state_q == S_WAIT) || (state_q == S_JUDGE);
  assign game_over = (state_q == S_OVER);
  assign dbg_state = state_q;

endmodule
